// File: rtl/rtl_bd.sv
// rtl_bd -- ADC sample bank.
//
// Decimates a free-running ADC stream. It takes one sample every DIV clocks
// and keeps the last 2**AVG_LOG2 samples in a shift-register history bank.
// BD_DATA_0 shows the newest captured sample. BD_DATA_1 shows the floor mean
// of the window.
// Define RTL_BD_PEAK_HOLD_EN to make BD_DATA_1 the window peak instead. That
// build does not include the running-sum register.
//
// Ports
//   clk            in   1       single clock, rising edge
//   rst            in   1       synchronous reset, active-low
//   conversor_adc  in   DATA_W  raw ADC sample, looked at on strobe cycles only
//   BD_DATA_0      out  DATA_W  newest captured sample, registered
//   BD_DATA_1      out  DATA_W  window mean (or peak), registered
//
// Parameters
//   DATA_W    sample width
//   DIV       decimation factor, >= 1
//   AVG_LOG2  log2 of window depth, 1..4
module rtl_bd #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DIV      = 4,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] conversor_adc,
  output logic [DATA_W-1:0] BD_DATA_0,
  output logic [DATA_W-1:0] BD_DATA_1
);

  localparam int unsigned N     = 1 << AVG_LOG2;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic              w_strobe;
  logic [DATA_W-1:0] r_hist [N];
  logic [DATA_W-1:0] w_result;

  // With DIV==1 the counter stays at 0, so the strobe is asserted every cycle.
  assign w_strobe = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      BD_DATA_0 <= '0;
      BD_DATA_1 <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      if (w_strobe) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_strobe) begin
        r_hist[0] <= conversor_adc;
        for (int unsigned i = 1; i < N; i++) begin
          r_hist[i] <= r_hist[i-1];
        end
        BD_DATA_0 <= conversor_adc;
        BD_DATA_1 <= w_result;
      end
    end
  end

`ifdef RTL_BD_PEAK_HOLD_EN
  // The new window is the incoming sample plus h[0..N-2]. h[N-1] is about to
  // be dropped, so it is not part of the comparison.
  always_comb begin
    w_result = conversor_adc;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (r_hist[i] > w_result) begin
        w_result = r_hist[i];
      end
    end
  end
`else
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum_next;

  // r_sum always contains h[N-1], so the subtraction cannot underflow.
  assign w_sum_next = r_sum + SUM_W'(conversor_adc) - SUM_W'(r_hist[N-1]);
  assign w_result   = w_sum_next[SUM_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_strobe) begin
      r_sum <= w_sum_next;
    end
  end
`endif

endmodule

// File: tb/tb_rtl_bd.sv
module tb_rtl_bd;

  localparam int DATA_W   = 8;
  localparam int DIV      = 4;
  localparam int AVG_LOG2 = 2;
  localparam int N        = 1 << AVG_LOG2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] adc = '0;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;

  int tests  = 0;
  int failed = 0;

  rtl_bd #(.DATA_W(DATA_W), .DIV(DIV), .AVG_LOG2(AVG_LOG2)) dut (
    .clk           (clk),
    .rst           (rst),
    .conversor_adc (adc),
    .BD_DATA_0     (d0),
    .BD_DATA_1     (d1)
  );

  always #5 clk = ~clk;

  // Reference model: a window of the last N samples plus a count of edges
  // since the last reset.
  int m_win[$];
  int m_edges;
  int m_d0;
  int m_d1;

  function automatic void model_edge(input bit r, input int s);
    int acc;
    if (!r) begin
      m_win = {};
      for (int i = 0; i < N; i++) m_win.push_back(0);
      m_edges = 0;
      m_d0 = 0;
      m_d1 = 0;
    end else begin
      m_edges++;
      if (m_edges % DIV == 0) begin
        m_win.push_front(s);
        void'(m_win.pop_back());
        m_d0 = s;
`ifdef RTL_BD_PEAK_HOLD_EN
        acc = 0;
        foreach (m_win[k]) if (m_win[k] > acc) acc = m_win[k];
        m_d1 = acc;
`else
        acc = 0;
        foreach (m_win[k]) acc += m_win[k];
        m_d1 = acc / N;
`endif
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the inputs for one edge, then compares the outputs against the
  // model 1 time unit after that edge.
  task automatic edge_step(input bit r, input logic [DATA_W-1:0] s);
    rst = r;
    adc = s;
    @(posedge clk);
    model_edge(r, int'(s));
    #1;
    chk("d0_model", int'(d0), m_d0);
    chk("d1_model", int'(d1), m_d1);
  endtask

  typedef struct {
    bit              do_rst;
    logic [DATA_W-1:0] smp;
    logic [DATA_W-1:0] e0;
    logic [DATA_W-1:0] e1;
  } vec_t;

  function automatic vec_t mk(input bit r, input int s, input int e0, input int e1);
    vec_t v;
    v.do_rst = r;
    v.smp = DATA_W'(s);
    v.e0  = DATA_W'(e0);
    v.e1  = DATA_W'(e1);
    return v;
  endfunction

  vec_t vecs[$];
  logic [DATA_W-1:0] held;
  logic [DATA_W-1:0] s;

  initial begin
`ifdef RTL_BD_PEAK_HOLD_EN
    vecs.push_back(mk(1, 10, 10, 10));
    vecs.push_back(mk(0, 80, 80, 80));
    vecs.push_back(mk(0, 20, 20, 80));
    vecs.push_back(mk(0, 30, 30, 80));
    vecs.push_back(mk(0,  5,  5, 80));
    vecs.push_back(mk(0,  5,  5, 30));
    vecs.push_back(mk(0,  5,  5, 30));
    vecs.push_back(mk(0,  5,  5,  5));
`else
    vecs.push_back(mk(1, 'h40, 'h40, 'h10));
    vecs.push_back(mk(0, 'h40, 'h40, 'h20));
    vecs.push_back(mk(0, 'h40, 'h40, 'h30));
    vecs.push_back(mk(0, 'h40, 'h40, 'h40));
    vecs.push_back(mk(1, 'hFF, 'hFF, 'h3F));
    vecs.push_back(mk(0, 'hFF, 'hFF, 'h7F));
    vecs.push_back(mk(0, 'hFF, 'hFF, 'hBF));
    vecs.push_back(mk(0, 'hFF, 'hFF, 'hFF));
    vecs.push_back(mk(0, 'hFF, 'hFF, 'hFF));
    vecs.push_back(mk(1, 3, 3, 0));
    vecs.push_back(mk(0, 3, 3, 1));
    vecs.push_back(mk(0, 3, 3, 2));
    vecs.push_back(mk(0, 2, 2, 2));
    vecs.push_back(mk(0, 0, 0, 2));
`endif

    // Before the first reset edge the outputs are undefined, so they are not checked here.
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset value, then the outputs must hold at zero for 3 edges after release.
    edge_step(1'b0, 8'h5A);
    chk("reset_d0", int'(d0), 0);
    chk("reset_d1", int'(d1), 0);
    for (int e = 1; e < DIV; e++) begin
      edge_step(1'b1, 8'hAA);
      chk("hold_d0", int'(d0), 0);
      chk("hold_d1", int'(d1), 0);
    end
    edge_step(1'b1, 8'hAA);
    chk("first_strobe_d0", int'(d0), 'hAA);

    // Directed table: each record holds one sample for one decimation period.
    foreach (vecs[v]) begin
      if (vecs[v].do_rst) edge_step(1'b0, '0);
      for (int e = 0; e < DIV; e++) edge_step(1'b1, vecs[v].smp);
      chk($sformatf("vec%0d_d0", v), int'(d0), int'(vecs[v].e0));
      chk($sformatf("vec%0d_d1", v), int'(d1), int'(vecs[v].e1));
    end

    // Decimation: the input changes every clock; D0 follows only the strobe edges.
    edge_step(1'b0, '0);
    held = '0;
    for (int e = 1; e <= 4 * DIV; e++) begin
      s = DATA_W'($urandom);
      edge_step(1'b1, s);
      if (e % DIV == 0) held = s;
      chk("decim_d0", int'(d0), int'(held));
    end

    // Mid-stream reset after 2 strobes. The reset lands on an edge that would
    // otherwise be a strobe, so reset must win.
    edge_step(1'b0, '0);
    for (int e = 1; e < 3 * DIV; e++) edge_step(1'b1, 8'h80);
    edge_step(1'b0, 8'hFF);
    chk("midrst_d0", int'(d0), 0);
    chk("midrst_d1", int'(d1), 0);
    for (int e = 1; e < DIV; e++) edge_step(1'b1, 8'h9C);
    chk("midrst_hold_d0", int'(d0), 0);
    edge_step(1'b1, 8'h9C);
    chk("midrst_strobe_d0", int'(d0), 'h9C);
`ifdef RTL_BD_PEAK_HOLD_EN
    chk("midrst_strobe_d1", int'(d1), 'h9C);
`else
    chk("midrst_strobe_d1", int'(d1), 'h27);
`endif

    // Random stream with occasional resets, checked against the model.
    for (int e = 0; e < 600; e++) begin
      edge_step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, DATA_W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
